// File: rtl/plant_pkg.sv
// Shared widths, types and LFSR constants for the first-order plant model.
package plant_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_FRAC_W = 8;
    localparam int STATE_W        = DEFAULT_DATA_W + DEFAULT_FRAC_W;

    typedef logic [STATE_W-1:0]        state_t;
    typedef logic [DEFAULT_DATA_W-1:0] sample_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 expressed as zero-based bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/plant_delay_line.sv
// Transport-delay shift register: dout is the value pushed DEPTH pushes ago; DEPTH=0 passes din through.
module plant_delay_line
    import plant_pkg::*;
#(
    parameter int W     = DEFAULT_DATA_W,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_ok;
            assign unused_ok = &{1'b0, clk, rst_n, push};
            assign dout = din;
        end else begin : g_shift
            logic [W-1:0] mem [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
                end else if (push) begin
                    mem[0] <= din;
                    for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
                end
            end

            // Read happens before the push, so the oldest entry is exactly DEPTH ticks old
            assign dout = mem[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/plant_model.sv
// Discrete first-order plant with transport delay, updated once every TICK_DIV clocks.
// Define PLANT_NOISE_EN to add LFSR noise (-4..+3) to the output; the state itself stays clean.
module plant_model
    import plant_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int FRAC_W   = DEFAULT_FRAC_W,
    parameter int TICK_DIV = 16,
    parameter int SHIFT_K  = 3,
    parameter int DELAY_N  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [DATA_W-1:0] ctrl_in,
    input  logic              load,
    input  logic [DATA_W-1:0] load_val,
    output logic [DATA_W-1:0] feedback_out,
    output logic              sample_valid
);

    localparam int SW    = DATA_W + FRAC_W;
    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0]      cnt;
    logic                  tick;
    logic                  push;
    logic                  do_load;
    logic [DATA_W-1:0]     u_d;
    logic [SW-1:0]         y;
    logic [SW-1:0]         y_next;
    logic signed [SW+1:0]  diff;
    logic signed [SW+1:0]  sum;
    logic [DATA_W-1:0]     out_val;

    assign tick    = ena && (cnt == CNT_MAX);
    assign do_load = ena && load;
    // A load on a tick cycle suppresses both the push and the state update
    assign push    = tick && !load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (ena) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

    plant_delay_line #(
        .W     (DATA_W),
        .DEPTH (DELAY_N)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (ctrl_in),
        .dout  (u_d)
    );

    // Two guard bits: one for sign, one to catch overflow past full scale before clamping
    always_comb begin
        diff = $signed({2'b00, u_d, {FRAC_W{1'b0}}}) - $signed({2'b00, y});
        sum  = $signed({2'b00, y}) + (diff >>> SHIFT_K);
        if (sum[SW+1])
            y_next = '0;
        else if (sum[SW])
            y_next = '1;
        else
            y_next = sum[SW-1:0];
    end

`ifdef PLANT_NOISE_EN
    logic [15:0]       lfsr;
    logic [DATA_W+1:0] noisy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else if (push) begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    always_comb begin
        noisy = {2'b00, y_next[SW-1:FRAC_W]} + (DATA_W+2)'(lfsr[2:0]) - (DATA_W+2)'(4);
        if (noisy[DATA_W+1])
            out_val = '0;
        else if (noisy[DATA_W])
            out_val = '1;
        else
            out_val = noisy[DATA_W-1:0];
    end
`else
    assign out_val = y_next[SW-1:FRAC_W];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y <= '0;
        end else if (do_load) begin
            y <= {load_val, {FRAC_W{1'b0}}};
        end else if (tick) begin
            y <= y_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feedback_out <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (do_load) begin
                feedback_out <= load_val;
                sample_valid <= 1'b1;
            end else if (tick) begin
                feedback_out <= out_val;
                sample_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_plant_model.sv
// Self-checking bench for plant_model: directed scenarios plus random stimulus against a tick-level reference model.
module tb_plant_model;

    localparam int TD = 16;
    localparam int K  = 3;
    localparam int D  = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ctrl_in;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] fb;
    logic       sv;

    logic       ena2;
    logic [7:0] ctrl2;
    logic       load2;
    logic [7:0] load_val2;
    logic [7:0] fb2;
    logic       sv2;

    int checks = 0;
    int errors = 0;

    int m_cnt;
    int m_y;
    int m_fb;
    bit m_sv;
    int m_q[$];

    always #5 clk = ~clk;

    plant_model dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .ctrl_in      (ctrl_in),
        .load         (load),
        .load_val     (load_val),
        .feedback_out (fb),
        .sample_valid (sv)
    );

    plant_model #(.SHIFT_K(0), .DELAY_N(0)) dut_fast (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena2),
        .ctrl_in      (ctrl2),
        .load         (load2),
        .load_val     (load_val2),
        .feedback_out (fb2),
        .sample_valid (sv2)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_fb(input string tag, input int obs, input int exp);
        checks++;
`ifdef PLANT_NOISE_EN
        assert (obs >= exp - 4 && obs <= exp + 4 && obs >= 0 && obs <= 255) else begin
            errors++;
            $error("[TB] FAIL %s observed %0d expected %0d +-4", tag, obs, exp);
        end
`else
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
`endif
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_y   = 0;
        m_fb  = 0;
        m_sv  = 0;
        m_q.delete();
        repeat (D) m_q.push_back(0);
    endtask

    // Tick-level reference: history queue of pushed efforts, exponential approach with floor division
    task automatic model_step();
        bit tick;
        int ud;
        int diff;
        int step;
        int scale;
        m_sv = 0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (!ena) return;
        tick  = (m_cnt == TD - 1);
        m_cnt = tick ? 0 : m_cnt + 1;
        if (load) begin
            m_y  = load_val * 256;
            m_fb = load_val;
            m_sv = 1;
        end else if (tick) begin
            ud = m_q.pop_front();
            m_q.push_back(int'(ctrl_in));
            diff  = ud * 256 - m_y;
            scale = 1 << K;
            step  = (diff >= 0) ? diff / scale : -((-diff + scale - 1) / scale);
            m_y   = m_y + step;
            if (m_y < 0) m_y = 0;
            if (m_y > 65535) m_y = 65535;
            m_fb = m_y / 256;
            m_sv = 1;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
        check_eq("valid", int'(sv), int'(m_sv));
        check_fb("feedback", int'(fb), m_fb);
    endtask

    task automatic step_up_check();
        int pulses;
        pulses  = 0;
        ctrl_in = 8'd200;
        while (pulses < 200) begin
            cycle();
            if (m_sv) begin
                pulses++;
                if (pulses <= 4)
                    check_fb("step_hold", int'(fb), 0);
                else if (pulses == 5)
                    check_fb("step_p5", int'(fb), 25);
                else if (pulses == 6)
                    check_fb("step_p6", int'(fb), 46);
            end
        end
        check_fb("step_final", int'(fb), 199);
        pulses = 0;
        while (pulses < 3) begin
            cycle();
            if (m_sv) pulses++;
        end
        check_fb("step_stable", int'(fb), 199);
    endtask

    task automatic wait_fast_pulse(input string tag);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!sv2 && n < 40);
        check_eq(tag, int'(sv2), 1);
    endtask

    initial begin
        int pulses;
        int n;

        rst_n     = 1'b0;
        ena       = 1'b1;
        ctrl_in   = 8'd0;
        load      = 1'b0;
        load_val  = 8'd0;
        ena2      = 1'b1;
        ctrl2     = 8'd0;
        load2     = 1'b0;
        load_val2 = 8'd0;
        model_reset();

        repeat (3) cycle();
        check_eq("reset_fb", int'(fb), 0);
        check_eq("reset_valid", int'(sv), 0);
        rst_n = 1'b1;

        $display("[TB] scenario: step up");
        step_up_check();

        $display("[TB] scenario: step down");
        ctrl_in = 8'd0;
        pulses  = 0;
        while (pulses < 150) begin
            cycle();
            if (m_sv) begin
                pulses++;
                if (pulses <= 4)
                    check_fb("down_hold", int'(fb), 199);
                else if (pulses == 5)
                    check_fb("down_p5", int'(fb), 174);
            end
        end
        check_fb("down_final", int'(fb), 0);

        $display("[TB] scenario: ena freeze");
        ctrl_in = 8'd150;
        pulses  = 0;
        while (pulses < 7) begin
            cycle();
            if (m_sv) pulses++;
        end
        repeat (5) cycle();
        ena = 1'b0;
        repeat (100) cycle();
        ena = 1'b1;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!sv && n < 40);
        check_eq("resume_latency", n, TD - 5);

        $display("[TB] scenario: random stimulus");
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) ctrl_in = 8'($urandom);
            ena      = ($urandom_range(0, 9) != 0);
            load     = ena && ($urandom_range(0, 63) == 0);
            load_val = 8'($urandom);
            cycle();
        end
        ena  = 1'b1;
        load = 1'b0;

        $display("[TB] scenario: load on tick");
        n = 0;
        while (m_cnt != TD - 1 && n < 2 * TD) begin
            cycle();
            n++;
        end
        load     = 1'b1;
        load_val = 8'd128;
        cycle();
        check_eq("load_value", int'(fb), 128);
        check_eq("load_valid", int'(sv), 1);
        load    = 1'b0;
        ctrl_in = 8'd60;
        pulses  = 0;
        while (pulses < 10) begin
            cycle();
            if (m_sv) pulses++;
        end

        $display("[TB] scenario: fast plant saturation");
        ctrl2 = 8'd255;
        wait_fast_pulse("fast_pulse_hi");
        check_fb("fast_full", int'(fb2), 255);
        ctrl2 = 8'd0;
        wait_fast_pulse("fast_pulse_lo");
        check_fb("fast_zero", int'(fb2), 0);

        $display("[TB] scenario: async reset mid-transient");
        ctrl_in = 8'd90;
        pulses  = 0;
        while (pulses < 8) begin
            cycle();
            if (m_sv) pulses++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_fb", int'(fb), 0);
        check_eq("async_valid", int'(sv), 0);
        check_eq("async_fb_fast", int'(fb2), 0);
        model_reset();
        ctrl_in = 8'd0;
        repeat (2) cycle();
        rst_n = 1'b1;
        step_up_check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
